wb_host_master: RTL
===================

Name: wb_host_master

Overview:
- Single-outstanding Wishbone B4 pipelined master.
- Sits directly upstream of the generated register-bank slaves.
- Converts a simple host request/acknowledge port (CPU bridge, test sequencer) into one Wishbone cycle per request.
- Handles stall, ack, err and rty, with a bounded retry count and a response timeout.

Parameters:
- ADDR_W, 1: word-address width; drives wb_adr_o[ADDR_W+1:2].
- TIMEOUT, 255: cycles allowed from cycle start to ack/err/rty before abort; must be >= 1.
- MAX_RETRY, 3: rty responses re-issued before reporting error; 0 means no retry.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- host_req_i  in  1  request strobe; sampled only when host_busy_o=0.
- host_we_i  in  1  1=write, 0=read.
- host_adr_i  in  ADDR_W  word address.
- host_sel_i  in  4  byte lanes.
- host_dat_i  in  32  write data.
- host_busy_o  out  1  transaction in progress.
- host_ack_o  out  1  one-cycle completion pulse.
- host_err_o  out  1  qualifies host_ack_o: err, timeout or retries exhausted.
- host_dat_o  out  32  read data, valid with host_ack_o; held until next completion.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_adr_o  out  ADDR_W  address, bits [ADDR_W+1:2].
- wb_sel_o  out  4  byte select.
- wb_we_o  out  1  write enable.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error response.
- wb_rty_i  in  1  retry response.
- wb_stall_i  in  1  pipeline stall.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including host_dat_o and wb_dat_o.
  - Timeout and retry counters 0.
  - Reset mid-cycle drops cyc/stb immediately; no host_ack_o is produced for the aborted transaction.
- Host accept:
  - In IDLE with host_req_i=1, capture adr/sel/we/dat into holding registers.
  - Next cycle: state=ISSUE, cyc=stb=1, busy=1.
  - host_req_i while busy is ignored; no queueing.
- ISSUE:
  - stb held with stable adr/dat/sel/we while wb_stall_i=1.
  - On a cycle with wb_stall_i=0, stb drops next cycle and state goes to WAIT.
  - A response (ack/err/rty) in the same cycle as stall=0 is handled as a WAIT response; WAIT is skipped.
  - Slaves that hold stall high until ack are supported: minimum latency is 2 cycles after stb.
- WAIT:
  - cyc=1, stb=0, until ack, err or rty.
  - Priority when several are asserted: err > rty > ack.
- Completion on ack:
  - Next cycle: cyc=0, state=IDLE, host_ack_o=1, host_err_o=0, busy=0.
  - For reads, host_dat_o <= wb_dat_i captured in the ack cycle.
  - A new host request is accepted in that same cycle.
- Completion on err: same as ack, but host_err_o=1 and host_dat_o unchanged.
- Retry on rty:
  - If retry count < MAX_RETRY: increment it, drop cyc for exactly one cycle (state=BACKOFF), then re-enter ISSUE with the same captured request.
  - Otherwise complete with host_err_o=1.
- Timeout:
  - Counter clears on entering ISSUE (including after BACKOFF) and increments every cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT with no response: cyc/stb drop and the block completes with host_err_o=1.
  - A response arriving in the same cycle as the terminal count wins over the timeout.
- Counter widths: clog2(TIMEOUT+1) and clog2(MAX_RETRY+1); no wrap possible.
- States: IDLE, ISSUE, WAIT, BACKOFF.
- Stray wb_ack_i/err/rty while cyc=0 is ignored.

Decomposition:
- Package wb_host_pkg:
  - state enum t_wbm_state {IDLE, ISSUE, WAIT, BACKOFF}.
  - Response-code constants RESP_OK, RESP_ERR, RESP_TMO, RESP_RTY_EXH for bench checkers.
- One sub-module, wb_host_timer: loadable saturating down-counter with clear/enable/expired, reused for timeout.
- The FSM stays in the top module.

Test Plan:
- Read, no stall: slave acks 2 cycles after stb with wb_dat_i=0xDEADBEEF, adr=1 -> host_ack_o pulse, host_err_o=0, host_dat_o=0xDEADBEEF, busy low the same cycle.
- Write under stall: wb_stall_i=1 for 5 cycles then 0 with ack -> stb held 6 cycles, adr/dat/sel stable (dat=0x12345678, sel=0xF), single ack pulse.
- Retry: rty returned 2 times then ack, MAX_RETRY=3 -> two BACKOFF cycles with cyc=0, three strobes total, final host_err_o=0; with 4 rty responses -> host_err_o=1 after the 4th.
- Timeout: TIMEOUT=8, no response -> cyc drops after exactly 8 cycles, host_ack_o=1 with host_err_o=1, host_dat_o retains its previous value.
- Priority and boundary: err+ack asserted together -> host_err_o=1; ack on the terminal timeout cycle -> host_err_o=0.
- Reset and back-to-back: rst_n_i low mid-WAIT -> outputs 0 immediately, no ack pulse; after release, host_req_i held high -> back-to-back transactions with one IDLE/accept cycle between cycles.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the single-outstanding Wishbone host master.
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } t_wbm_state;

  // Completion codes; anything other than RESP_OK raises host_err_o.
  localparam logic [1:0] RESP_OK      = 2'd0;
  localparam logic [1:0] RESP_ERR     = 2'd1;
  localparam logic [1:0] RESP_TMO     = 2'd2;
  localparam logic [1:0] RESP_RTY_EXH = 2'd3;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_host_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module wb_host_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/wb_host_master.sv
// Host request/ack port to one Wishbone B4 pipelined cycle per request, with retry and timeout.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned ADDR_W    = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_adr_i,
  input  logic [3:0]        host_sel_i,
  input  logic [31:0]       host_dat_i,
  output logic              host_busy_o,
  output logic              host_ack_o,
  output logic              host_err_o,
  output logic [31:0]       host_dat_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i
);

  localparam int unsigned TMR_W = cnt_w(TIMEOUT);
  localparam int unsigned RTY_W = cnt_w(MAX_RETRY);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ISSUE   = ISSUE;
  localparam logic [1:0] ST_WAIT    = WAIT;
  localparam logic [1:0] ST_BACKOFF = BACKOFF;

  logic [1:0]        state, state_nxt;
  logic [RTY_W-1:0]  retry_cnt;
  logic [ADDR_W-1:0] adr_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [31:0]       dat_q;

  logic       in_cycle, resp_window, accept;
  logic       done, retry, capture;
  logic [1:0] resp_code;
  logic       tmr_load, tmr_clr, tmr_expired;

  assign in_cycle = (state == ST_ISSUE) || (state == ST_WAIT);
  // The strobe is accepted on a non-stalled ISSUE cycle, so a response there counts as a WAIT response.
  assign resp_window = (state == ST_WAIT) || ((state == ST_ISSUE) && !wb_stall_i);
  assign accept = (state == ST_IDLE) && host_req_i;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    retry     = 1'b0;
    capture   = 1'b0;
    resp_code = RESP_OK;
    case (state)
      ST_IDLE:    if (host_req_i) state_nxt = ST_ISSUE;
      ST_BACKOFF: state_nxt = ST_ISSUE;
      default: begin
        if (resp_window && wb_err_i) begin
          done      = 1'b1;
          resp_code = RESP_ERR;
        end else if (resp_window && wb_rty_i) begin
          if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry = 1'b1;
          end else begin
            done      = 1'b1;
            resp_code = RESP_RTY_EXH;
          end
        end else if (resp_window && wb_ack_i) begin
          done    = 1'b1;
          capture = !we_q;
        end else if (tmr_expired) begin
          done      = 1'b1;
          resp_code = RESP_TMO;
        end else if ((state == ST_ISSUE) && !wb_stall_i) begin
          state_nxt = ST_WAIT;
        end
        if (done) begin
          state_nxt = ST_IDLE;
        end else if (retry) begin
          state_nxt = ST_BACKOFF;
        end
      end
    endcase
  end

  // Loaded so that it expires on the TIMEOUT-th cycle of ISSUE/WAIT.
  assign tmr_load = accept || (state == ST_BACKOFF);
  assign tmr_clr  = done || retry;

  wb_host_timer #(.W(TMR_W)) u_timer (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (TMR_W'(TIMEOUT - 1)),
    .en       (in_cycle),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      retry_cnt  <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      host_ack_o <= 1'b0;
      host_err_o <= 1'b0;
      host_dat_o <= '0;
    end else begin
      state      <= state_nxt;
      host_ack_o <= done;
      host_err_o <= done && (resp_code != RESP_OK);
      if (capture) host_dat_o <= wb_dat_i;
      if (accept) begin
        adr_q     <= host_adr_i;
        sel_q     <= host_sel_i;
        we_q      <= host_we_i;
        dat_q     <= host_dat_i;
        retry_cnt <= '0;
      end else if (retry) begin
        retry_cnt <= retry_cnt + RTY_W'(1);
      end
    end
  end

  assign host_busy_o = (state != ST_IDLE);
  assign wb_cyc_o    = in_cycle;
  assign wb_stb_o    = (state == ST_ISSUE);
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_dat_o    = dat_q;

endmodule
